// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU: opcode field width, opcode constants
// and the fetch front-end state encoding.
package cpu_pkg;

  localparam int unsigned OPCODE_W = 3;

  localparam logic [OPCODE_W-1:0] OPC_DTYPE = 3'b000;
  localparam logic [OPCODE_W-1:0] OPC_I1    = 3'b001;
  localparam logic [OPCODE_W-1:0] OPC_I2    = 3'b010;
  localparam logic [OPCODE_W-1:0] OPC_ST    = 3'b011;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding read to instruction memory, a single
// hold register offered to decode, and wrong-path discard on execute redirects.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 16,
  parameter int unsigned        INSTR_W  = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req,
  output logic [ADDR_W-1:0]    imem_addr,
  input  logic                 imem_ready,
  input  logic                 imem_rvalid,
  input  logic [INSTR_W-1:0]   imem_rdata,
  output logic                 if_valid,
  output logic [INSTR_W-1:0]   if_instr,
  output logic [OPCODE_W-1:0]  if_opcode,
  output logic [ADDR_W-1:0]    if_pc,
  input  logic                 id_ready,
  input  logic                 redirect_valid,
  input  logic [ADDR_W-1:0]    redirect_pc,
  output logic [15:0]          fetch_count
);

  fetch_state_t        state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic                drop_q;
  logic [INSTR_W-1:0]  instr_q;
  logic [ADDR_W-1:0]   if_pc_q;
  logic [15:0]         count_q;
  logic                req_acc;

  assign imem_req    = rst_n & (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign req_acc     = imem_req & imem_ready;
  // The held instruction is always younger than the redirecting one, so hide it.
  assign if_valid    = (state_q == HOLD) & ~redirect_valid;
  assign if_instr    = instr_q;
  assign if_opcode   = instr_q[INSTR_W-1 -: OPCODE_W];
  assign if_pc       = if_pc_q;
  assign fetch_count = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      instr_q <= '0;
      if_pc_q <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        FETCH: begin
          // A late response from before reset lands here and is ignored.
          if (redirect_valid) pc_q <= redirect_pc;
          if (req_acc) begin
            state_q <= WAIT;
            if (redirect_valid) drop_q <= 1'b1;
          end
        end
        WAIT: begin
          if (redirect_valid) pc_q <= redirect_pc;
          if (imem_rvalid) begin
            if (drop_q || redirect_valid) begin
              drop_q  <= 1'b0;
              state_q <= FETCH;
            end else begin
              instr_q <= imem_rdata;
              if_pc_q <= pc_q;
              pc_q    <= pc_q + ADDR_W'(1);
              state_q <= HOLD;
            end
          end else if (redirect_valid) begin
            drop_q <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc_q    <= redirect_pc;
            state_q <= FETCH;
          end else if (id_ready) begin
            count_q <= count_q + 16'd1;
            state_q <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural memory, an in-order delivery model and
// directed phases covering timing, backpressure, redirects and reset.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [2:0]  if_opcode;
  logic [15:0] if_pc;
  logic        id_ready;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] fetch_count;

  // Second instance with a wrapping reset PC.
  logic        rst_nb;
  logic        b_req;
  logic [15:0] b_addr;
  logic        b_ready;
  logic        b_rvalid;
  logic [15:0] b_rdata;
  logic        b_valid;
  logic [15:0] b_instr;
  logic [2:0]  b_opc;
  logic [15:0] b_pc;
  logic [15:0] b_cnt;
  logic        b_done;

  int total = 0;
  int bad   = 0;
  int lat;
  logic mem_en;

  fetch_unit #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_opcode(if_opcode), .if_pc(if_pc),
    .id_ready(id_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_count(fetch_count)
  );

  fetch_unit #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'hFFFF)) u_dut_b (
    .clk(clk), .rst_n(rst_nb), .imem_req(b_req), .imem_addr(b_addr),
    .imem_ready(b_ready), .imem_rvalid(b_rvalid), .imem_rdata(b_rdata),
    .if_valid(b_valid), .if_instr(b_instr), .if_opcode(b_opc), .if_pc(b_pc),
    .id_ready(1'b1), .redirect_valid(1'b0), .redirect_pc(16'h0000),
    .fetch_count(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: addresses 0..2 hold 2000/4000/6000, others a mixed pattern.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [2:0] t;
    t = a[2:0] + 3'd1;
    if (a < 16'd3) return {t, 13'd0};
    return {t, a[12:0] ^ 13'h0AAA};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: drives at negedge, samples acceptance one unit before posedge.
  initial begin
    logic        pend;
    int          cnt;
    logic [15:0] paddr;
    pend = 1'b0; cnt = 0; paddr = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) pend = 1'b0;
      imem_rvalid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(paddr);
          pend        = 1'b0;
        end
      end
      imem_ready = mem_en && !pend && !imem_rvalid;
      #4;
      if (imem_req && imem_ready) begin
        pend = 1'b1; cnt = lat; paddr = imem_addr;
      end
    end
  end

  // Delivery model: instructions reach decode in PC order from the last reset or
  // redirect target; every redirect discards anything younger.
  initial begin
    logic [15:0] exp_pc, exp_cnt, prev_instr, prev_pc;
    logic        prev_hold;
    exp_pc = 16'h0000; exp_cnt = '0; prev_hold = 1'b0; prev_instr = '0; prev_pc = '0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", if_valid, 1'b0);
        chk("rst_count", fetch_count, 16'd0);
        exp_pc = 16'h0000; exp_cnt = '0; prev_hold = 1'b0;
      end else begin
        chk("count", fetch_count, exp_cnt);
        if (prev_hold) begin
          if (!redirect_valid) chk("hold_valid", if_valid, 1'b1);
          chk("hold_instr", if_instr, prev_instr);
          chk("hold_pc", if_pc, prev_pc);
        end
        if (if_valid) begin
          chk("req_while_valid", imem_req, 1'b0);
          chk("order_pc", if_pc, exp_pc);
          chk("data", if_instr, mem_word(exp_pc));
          chk("opcode", if_opcode, {29'd0, if_instr[15:13]});
        end
        if (redirect_valid) begin
          chk("redir_valid", if_valid, 1'b0);
          exp_pc = redirect_pc;
        end else if (if_valid && id_ready) begin
          exp_pc  = exp_pc + 16'd1;
          exp_cnt = exp_cnt + 16'd1;
        end
        prev_hold  = if_valid && !id_ready;
        prev_instr = if_instr;
        prev_pc    = if_pc;
      end
    end
  end

  // Wrapping reset PC: FFFF then 0000.
  initial begin
    logic        acc;
    logic [15:0] aaddr;
    logic [15:0] bpc [2];
    logic [15:0] binstr [2];
    int          nb;
    b_done = 1'b0; rst_nb = 1'b0; b_ready = 1'b1; b_rvalid = 1'b0; b_rdata = '0;
    acc = 1'b0; aaddr = '0; nb = 0;
    repeat (2) @(negedge clk);
    rst_nb = 1'b1;
    for (int k = 0; k < 20; k++) begin
      b_rvalid = acc;
      b_rdata  = mem_word(aaddr);
      #4;
      acc   = b_req;
      aaddr = b_addr;
      if (b_valid && nb < 2) begin
        bpc[nb] = b_pc; binstr[nb] = b_instr; nb++;
      end
      @(negedge clk);
    end
    chk("wrap_n", nb, 2);
    if (nb == 2) begin
      chk("wrap_pc0", bpc[0], 16'hFFFF);
      chk("wrap_instr0", binstr[0], 16'h1555);
      chk("wrap_pc1", bpc[1], 16'h0000);
      chk("wrap_instr1", binstr[1], 16'h2000);
    end
    b_done = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          first;
    int          nv;
    int          vcyc [3];
    logic [15:0] vpc [3];
    logic [2:0]  vopc [3];
    logic [15:0] cnt9, h_instr, h_pc, h_cnt;
    logic        found;
    int          d;

    rst_n = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    mem_en = 1'b1; lat = 1;
    first = -1; nv = 0; cnt9 = '0;
    repeat (3) @(negedge clk);
    #4;
    chk("reset_addr", imem_addr, 16'h0000);
    chk("reset_instr", if_instr, 16'h0000);
    chk("reset_opcode", if_opcode, 3'b000);
    chk("reset_pc", if_pc, 16'h0000);

    // Zero-wait memory, decode always ready.
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #4;
      if (imem_req && first < 0) first = k;
      if (if_valid && nv < 3) begin
        vcyc[nv] = k - first; vpc[nv] = if_pc; vopc[nv] = if_opcode; nv++;
      end
      if (k == 9) cnt9 = fetch_count;
      @(negedge clk);
    end
    chk("first_req", first, 0);
    chk("n_valid", nv, 3);
    if (nv == 3) begin
      chk("vcyc0", vcyc[0], 2);
      chk("vcyc1", vcyc[1], 5);
      chk("vcyc2", vcyc[2], 8);
      chk("vpc0", vpc[0], 16'h0000);
      chk("vpc1", vpc[1], 16'h0001);
      chk("vpc2", vpc[2], 16'h0002);
      chk("vopc0", vopc[0], OPC_I1);
      chk("vopc1", vopc[1], OPC_I2);
      chk("vopc2", vopc[2], OPC_ST);
    end
    chk("count3", cnt9, 16'd3);

    // Backpressure in HOLD.
    id_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      #4;
      if (if_valid) found = 1'b1;
      else @(negedge clk);
    end
    chk("bp_wait", found, 1'b1);
    h_instr = if_instr; h_pc = if_pc; h_cnt = fetch_count;
    chk("bp_instr_val", h_instr, 16'h8AA9);
    chk("bp_pc_val", h_pc, 16'h0003);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #4;
      chk("bp_valid", if_valid, 1'b1);
      chk("bp_instr", if_instr, h_instr);
      chk("bp_pc", if_pc, h_pc);
      chk("bp_req", imem_req, 1'b0);
      chk("bp_count", fetch_count, h_cnt);
    end

    // Redirect while waiting; response arrives 3 cycles after the redirect.
    @(negedge clk);
    id_ready = 1'b1; lat = 4;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      #4;
      if (imem_req && imem_ready) found = 1'b1;
      else @(negedge clk);
    end
    chk("wr_accept", found, 1'b1);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    @(negedge clk);
    redirect_valid = 1'b0; lat = 1; id_ready = 1'b0;
    d = 1; found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      #4;
      chk("wr_no_valid", if_valid, 1'b0);
      if (imem_req) found = 1'b1;
      else begin @(negedge clk); d++; end
    end
    chk("wr_req", found, 1'b1);
    chk("wr_latency", d, 4);
    chk("wr_addr", imem_addr, 16'h0040);

    // Redirect in HOLD with decode ready in the same cycle.
    @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      #4;
      if (if_valid) found = 1'b1;
      else @(negedge clk);
    end
    chk("hr_wait", found, 1'b1);
    chk("hr_pc", if_pc, 16'h0040);
    chk("hr_instr", if_instr, 16'h2AEA);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 16'h0100; id_ready = 1'b1;
    #4;
    chk("hr_valid", if_valid, 1'b0);
    chk("hr_count_before", fetch_count, 16'd4);
    @(negedge clk);
    redirect_valid = 1'b0; lat = 5;
    #4;
    chk("hr_count_after", fetch_count, 16'd4);
    chk("hr_req", imem_req, 1'b1);
    chk("hr_addr", imem_addr, 16'h0100);

    // Asynchronous reset in the middle of an outstanding read.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_req", imem_req, 1'b0);
    chk("ar_addr", imem_addr, 16'h0000);
    chk("ar_valid", if_valid, 1'b0);
    chk("ar_instr", if_instr, 16'h0000);
    chk("ar_opcode", if_opcode, 3'b000);
    chk("ar_pc", if_pc, 16'h0000);
    chk("ar_count", fetch_count, 16'd0);
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; lat = 2;
    #4;
    chk("ar_release_req", imem_req, 1'b1);
    chk("ar_release_addr", imem_addr, 16'h0000);

    // Mixed decode backpressure with a slower memory.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      id_ready = (i % 3) != 1;
    end
    @(negedge clk);
    id_ready = 1'b1;

    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (b_done) found = 1'b1;
      else @(negedge clk);
    end
    chk("b_done", found, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end of the 16-bit CPU; it produces the instruction stream that the opcode decoder consumes. It holds the program counter, issues one read at a time to instruction memory, and presents each returned instruction with its 3-bit opcode and PC to decode under a valid/ready handshake. It discards wrong-path fetches when execute redirects the PC on a jump or a taken branch.

## Interface
- ADDR_W, 16, instruction-memory word-address width
- INSTR_W, 16, instruction width; opcode is instr[INSTR_W-1 -: 3]
- RESET_PC, 0, PC loaded at reset
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_req  out  1  read request
- imem_addr  out  ADDR_W  read address; stable while imem_req is high and unaccepted
- imem_ready  in  1  memory accepts the request when imem_req & imem_ready
- imem_rvalid  in  1  read data valid; exactly one per accepted request, at least 1 cycle after acceptance
- imem_rdata  in  INSTR_W  read data
- if_valid  out  1  instruction offered to decode
- if_instr  out  INSTR_W  instruction
- if_opcode  out  3  if_instr[INSTR_W-1 -: 3]
- if_pc  out  ADDR_W  word address of if_instr
- id_ready  in  1  decode accepts when if_valid & id_ready
- redirect_valid  in  1  jump or taken branch resolved in execute
- redirect_pc  in  ADDR_W  redirect target
- fetch_count  out  16  number of instructions handed to decode, wrapping

## Operation
- Three-state FSM:
  - FETCH: imem_req=1, imem_addr=pc.
    - Accept: go to WAIT.
  - WAIT: waiting for imem_rvalid.
    - rvalid with drop=0: latch rdata into the hold register, latch pc into if_pc, pc<=pc+1 (mod 2^ADDR_W, FFFF->0000), go to HOLD.
    - rvalid with drop=1: discard the data, clear drop, go to FETCH.
  - HOLD: held instruction is offered.
    - Handshake: fetch_count+1, go to FETCH.
- Redirect handling:
  - FETCH, no accept: pc<=redirect_pc; imem_addr changes the next cycle. This is legal because the request has not been accepted.
  - FETCH with accept in the same cycle: the request goes out with the old address; set drop, pc<=redirect_pc, go to WAIT.
  - WAIT: set drop, pc<=redirect_pc. If rvalid arrives in the same cycle, discard it and go to FETCH.
  - HOLD: discard the held instruction, pc<=redirect_pc, go to FETCH.
- redirect_valid always comes from an instruction older than the held one, so the held instruction is wrong-path. Consequences:
  - if_valid = (state==HOLD) & ~redirect_valid (combinational gate).
  - A handshake in the same cycle as a redirect does not count, and fetch_count is not incremented.
- Only one request is outstanding at a time. No internal stall source.
- Reset values (asynchronous, while rst_n=0):
  - state=FETCH, pc=RESET_PC, drop=0.
  - imem_req=0, imem_addr=RESET_PC.
  - if_valid=0, if_instr=0, if_opcode=0, if_pc=0, fetch_count=0.
  - imem_req is gated by rst_n. The first request is asserted in the first cycle after rst_n rises.
- Reset during an outstanding read: state is lost. A late imem_rvalid that arrives while in FETCH is ignored. The memory must not return data for a request from before reset after it accepts a new one.

## Timing
- Best case with zero-wait memory, one instruction every 3 cycles:
  - Cycle 0: FETCH, request accepted.
  - Cycle 1: WAIT, rvalid.
  - Cycle 2: HOLD, if_valid=1.
  - With id_ready=1, FETCH again in cycle 3.
- Decode backpressure holds HOLD indefinitely. if_instr, if_pc and if_opcode are stable while if_valid=1.
- Redirect-to-request latency:
  - From FETCH or HOLD: the new address appears 1 cycle after redirect_valid.
  - From WAIT: the new address appears 1 cycle after the dropped rvalid.
- The redirect_valid → if_valid path is the only combinational input-to-output path. There is no combinational path from id_ready to imem_req.

## Structure
- Shared cpu_pkg holds:
  - OPCODE_W=3.
  - Opcode constants: OPC_DTYPE=3'b000, OPC_I1=3'b001, OPC_I2=3'b010, OPC_ST=3'b011.
  - The fetch state enum {FETCH, WAIT, HOLD}.
- Single flat module with no sub-module. The PC incrementer and fetch_count are inline registers.

## Test plan
- Reset release, zero-wait memory returning 16'h2000, 16'h4000, 16'h6000 for addresses 0, 1, 2, id_ready=1:
  - if_valid pulses at cycles 2, 5 and 8 after the first request.
  - if_pc = 0, 1, 2 and if_opcode = 001, 010, 011.
  - fetch_count=3.
- id_ready=0 for 5 cycles during HOLD: if_instr and if_pc stay constant, imem_req=0, fetch_count is unchanged.
- Redirect to 16'h0040 while in WAIT with rvalid 3 cycles later:
  - The response is discarded and if_valid is never asserted for it.
  - Next imem_addr=16'h0040.
- Redirect to 16'h0100 in HOLD with id_ready=1 in the same cycle: if_valid=0 that cycle, fetch_count is unchanged, next imem_addr=16'h0100.
- RESET_PC=16'hFFFF, two fetches: if_pc=FFFF then 0000.
- rst_n dropped mid-WAIT: all outputs take their reset values immediately; after release, imem_addr=RESET_PC.
